if_fetch_ctrl: RTL

// Fetch-stage controller feeding the IF/ID register and the jump-examine flush logic. Owns the PC.

---
 rtl/if_fetch_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch-stage controller owning the PC, tracking the in-flight IROM read and feeding IF/ID
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      irom_addr_o,
  input  logic [31:0]      irom_inst_i,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_inst_o,
  output logic             if_id_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {RUN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, f1_pc_q, skid_inst_q, fetched;
  logic        f1_vld_q, advance;
  assign irom_addr_o = pc_q;
  // next state: redirect always returns to RUN, a stall parks in HOLD
  always_comb begin
    state_d = redirect_i ? RUN : (stall_i ? HOLD : RUN);
    advance = !redirect_i && !stall_i;
    fetched = (state_q == HOLD) ? skid_inst_q : irom_inst_i;
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end
  // PC, in-flight fetch, skid, IF/ID and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q           <= RESET_PC;
      f1_pc_q        <= '0;
      f1_vld_q       <= 1'b0;
      skid_inst_q    <= '0;
      if_id_pc_o     <= '0;
      if_id_inst_o   <= NOP;
      if_id_valid_o  <= 1'b0;
      misalign_o     <= 1'b0;
      redirect_cnt_o <= '0;
    end else if (redirect_i) begin
      pc_q           <= {redirect_pc_i[31:2], 2'b00};
      f1_vld_q       <= 1'b0;
      skid_inst_q    <= '0;
      if_id_inst_o   <= NOP;
      if_id_valid_o  <= 1'b0;
      misalign_o     <= misalign_o | (|redirect_pc_i[1:0]);
      redirect_cnt_o <= redirect_cnt_o + {{(CNT_W-1){1'b0}}, ~&redirect_cnt_o};
    end else if (advance) begin
      if_id_pc_o     <= f1_pc_q;
      if_id_inst_o   <= f1_vld_q ? fetched : NOP;
      if_id_valid_o  <= f1_vld_q;
      f1_pc_q        <= pc_q;
      f1_vld_q       <= 1'b1;
      pc_q           <= pc_q + 32'd4;
    end else if (state_q == RUN) begin
      skid_inst_q    <= irom_inst_i;
    end
  end
endmodule
